// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg                                                                   |
// | Shared types and constants for the SimpleRISC pipeline control logic.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam int c_def_num_stages = 4;

    // Pipeline register indices, bit positions in the stall vector.
    localparam int c_ifof  = 0;
    localparam int c_ofalu = 1;
    localparam int c_aludm = 2;
    localparam int c_dmwb  = 3;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter                                                                |
// | Saturating up-counter with synchronous clear (clear beats increment).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stall_ctrl                                                            |
// | Per-register stall/bubble generation from memory wait, halt, load-use and  |
// | memory-timeout fault, plus a saturating stall-cycle counter.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES  = c_def_num_stages,
    parameter int LU_STAGE    = 0,
    parameter bit STALL_ON_ST = 1'b0,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stop,
    input  logic                  resume,
    input  logic                  mem_is_ld,
    input  logic                  mem_is_st,
    input  logic                  mem_done,
    input  logic                  lu_hazard,
    input  logic                  fault_clr,
    input  logic                  perf_clr,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  bubble,
    output logic                  halted,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int                  c_wait_w   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_wait_w-1:0] c_tmo_lim  = c_wait_w'(TIMEOUT);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_wait_w-1:0]   r_wait_cnt;
    logic [c_wait_w-1:0]   w_wait_nxt;
    logic                  r_mem_timeout;
    logic                  w_tmo_nxt;
    logic [NUM_STAGES-1:0] w_stall;
    logic                  w_bubble;
    logic                  w_mreq;

    assign w_mreq = mem_is_ld | (STALL_ON_ST & mem_is_st);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_mem_timeout <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_tmo_nxt   = r_mem_timeout;
        w_stall     = '0;
        w_bubble    = 1'b0;
        case (r_state)
            FAULT: begin
                w_stall = '1;
                if (fault_clr) begin
                    w_state_nxt = RUN;
                    w_tmo_nxt   = 1'b0;
                    w_wait_nxt  = '0;
                end
            end
            HALTED: begin
                w_stall = '1;
                if (resume && !stop) begin
                    w_state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (stop) begin
                    w_stall     = '1;
                    w_state_nxt = HALTED;
                    w_wait_nxt  = '0;
                end else if (mem_done) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_stall = '1;
                    // Completion in the limit cycle still wins; only a miss faults.
                    if ((TIMEOUT != 0) && (r_wait_cnt == c_tmo_lim)) begin
                        w_state_nxt = FAULT;
                        w_tmo_nxt   = 1'b1;
                        w_wait_nxt  = '0;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (stop) begin
                    w_stall     = '1;
                    w_state_nxt = HALTED;
                    w_wait_nxt  = '0;
                end else if (w_mreq && !mem_done) begin
                    w_stall     = '1;
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = c_wait_one;
                end else if (lu_hazard) begin
                    // Freeze the front end and slip a NOP behind the load.
                    w_stall[LU_STAGE:0] = '1;
                    w_bubble            = 1'b1;
                end
            end
        endcase
    end

    assign stall       = rst_n ? w_stall : '1;
    assign bubble      = rst_n & w_bubble;
    assign halted      = (r_state == HALTED);
    assign mem_timeout = r_mem_timeout;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (stall[c_ifof]),
        .count (stall_cycles)
    );

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Parametrised pipeline stall/hazard controller for the SimpleRISC pipeline. Generalises the fixed 4-register stall logic.
- Drives one stall enable per pipeline register (IF/OF, OF/ALU, ALU/DM, DM/WB, ...) from four sources:
  - multi-cycle data-memory handshake (loads, and optionally stores);
  - sticky halt;
  - load-use hazard bubble insertion;
  - memory timeout fault.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- NUM_STAGES, 4, number of pipeline registers; width of stall vector; bit 0 = IF/OF.
- LU_STAGE, 0, highest register index frozen on a load-use hazard; bubble is injected into register LU_STAGE+1 (must be < NUM_STAGES-1).
- STALL_ON_ST, 0, 1 = stores also wait for mem_done; 0 = only loads wait.
- TIMEOUT, 64, maximum memory-wait cycles before FAULT; 0 disables the timeout.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stop  in  1  halt request (level); enters sticky halt.
- resume  in  1  leave halt; honoured only when stop=0.
- mem_is_ld  in  1  load present in DM stage.
- mem_is_st  in  1  store present in DM stage.
- mem_done  in  1  data memory completes the access this cycle.
- lu_hazard  in  1  OF stage reads the destination of a load currently in ALU stage.
- fault_clr  in  1  clears FAULT and mem_timeout.
- perf_clr  in  1  synchronous clear of stall_cycles.
- stall  out  NUM_STAGES  per-register hold enable (1 = hold).
- bubble  out  1  load register LU_STAGE+1 with a NOP this cycle.
- halted  out  1  state==HALTED.
- mem_timeout  out  1  sticky; memory access exceeded TIMEOUT.
- stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1.

Behaviour:
- State register, encoded as a localparam enum: RUN=0, MEM_WAIT=1, HALTED=2, FAULT=3.
- stall and bubble are combinational from state and current inputs (zero-cycle response). State, wait_cnt, mem_timeout and stall_cycles are registered.
- Reset (rst_n=0, async):
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, halted=0.
  - stall forced all-ones and bubble=0 for as long as rst_n=0.
- Define mreq = mem_is_ld | (STALL_ON_ST & mem_is_st).
- Priority, evaluated per cycle, highest first: FAULT > stop/HALTED > memory wait > load-use.
- FAULT:
  - stall=all ones, bubble=0, mem_timeout=1.
  - fault_clr → RUN, mem_timeout=0. Otherwise remain in FAULT.
  - stop is ignored while in FAULT.
- stop=1 in RUN or MEM_WAIT:
  - stall=all ones that same cycle; next state HALTED; wait_cnt cleared. An in-flight memory wait is abandoned.
- HALTED:
  - stall=all ones.
  - resume=1 with stop=0 → RUN next cycle; stall=all ones during the resume cycle itself.
  - stop and resume both 1 → stay HALTED.
- RUN:
  - mreq & !mem_done: stall=all ones, next state MEM_WAIT, wait_cnt=1.
  - mreq & mem_done: no stall (single-cycle access).
- MEM_WAIT:
  - mem_done=1: stall=0 that cycle, next state RUN, wait_cnt=0.
  - Otherwise stall=all ones and wait_cnt increments.
  - TIMEOUT≠0, wait_cnt==TIMEOUT and mem_done=0: next state FAULT. mem_done arriving in that same cycle wins (go to RUN, no fault).
  - wait_cnt width is clog2(TIMEOUT+1), minimum 1.
- Load-use (RUN only, no memory stall this cycle, lu_hazard=1):
  - stall[LU_STAGE:0]=1, all higher bits 0, bubble=1.
  - A single cycle per assertion; the hazard source deasserts once the load advances.
- bubble is always 0 whenever stall[LU_STAGE+1]=1.
- stall_cycles:
  - +1 on each cycle with stall[0]=1 and rst_n=1; saturates at 2^CNT_W-1.
  - perf_clr has priority over increment (clears to 0 that edge).

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (RUN/MEM_WAIT/HALTED/FAULT);
  - default NUM_STAGES;
  - stage-index constants (IFOF=0, OFALU=1, ALUDM=2, DMWB=3).
- Natural sub-module: sat_counter (parametrised CNT_W, inc, clr, saturation). Reused for stall_cycles and future perf counters.
- FSM and stall decode stay in pipe_stall_ctrl.

Test Plan:
- Reset with mem_is_ld=1 → stall=4'b1111 during reset. After rst_n rises with idle inputs → stall=0, stall_cycles=0.
- Load with mem_done rising on 3rd cycle → stall=1111 for cycles 1–2, 0 on cycle 3, state back to RUN, stall_cycles=2.
- TIMEOUT=4, load with mem_done never asserted → FAULT after the 4th wait cycle, mem_timeout=1, stall stuck at 1111. fault_clr → RUN and mem_timeout=0 next cycle.
- lu_hazard=1 for 1 cycle in RUN with LU_STAGE=0 → stall=4'b0001, bubble=1. Same pulse during MEM_WAIT → stall=1111, bubble=0.
- stop pulse during MEM_WAIT → HALTED, stall=1111 until resume. resume together with stop=1 → stays HALTED. resume alone → RUN next cycle.
- STALL_ON_ST=0: store with mem_done=0 → no stall. STALL_ON_ST=1: same stimulus → stall=1111. With CNT_W=4 and 20 stall cycles → stall_cycles saturates at 15.
